spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_clk_gen.sv | 41 ++++
 rtl/spi_controller.sv | 207 ++++++++++++++++++++
 tb/tb_spi_controller.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI write controller:
//   - SPI_FRAME_W     : serial frame length (write flag + 7-bit addr + 8-bit data)
//   - MAX_VALID_ADDR  : highest register address the peripheral implements
//   - ADDR_*          : register map of the attached peripheral
//   - spi_state_t     : controller FSM encoding (also exported for debug)
//   - build_frame()   : assembles the on-wire frame from a request
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int unsigned SPI_FRAME_W = 16;

  localparam logic [6:0] MAX_VALID_ADDR = 7'd4;

  // Peripheral register map
  localparam logic [6:0] ADDR_OUT_7_0   = 7'h00;
  localparam logic [6:0] ADDR_OUT_15_8  = 7'h01;
  localparam logic [6:0] ADDR_PWM_7_0   = 7'h02;
  localparam logic [6:0] ADDR_PWM_15_8  = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  // Bit 15 is the write flag and goes out first.
  function automatic logic [SPI_FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                         input logic [7:0] data);
    return {1'b1, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Half-period divider for the SPI controller. While enabled it emits a
// one-cycle tick every CLK_DIV clk cycles. The count restarts from zero when
// disabled, when cleared, and after every tick, so each phase the controller
// times starts from a known point.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_en     in   count enable
//   i_clear  in   synchronous restart of the count
//   o_tick   out  high on the last cycle of each CLK_DIV-cycle period
// -----------------------------------------------------------------------------
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [7:0] LP_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (!i_en || i_clear || o_tick) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// Write-only SPI master (mode 0). Each accepted request is sent as one 16-bit
// frame {1'b1, addr[6:0], data[7:0]}, MSB first, framed by ncs. After the
// frame ncs is held high for NCS_GAP cycles before the next request is taken.
//
// Optional feature: define SPI_CTRL_ADDR_CHECK_EN to reject requests whose
// address exceeds MAX_VALID_ADDR (no frame, one-cycle err pulse). Without it
// every address is transmitted and err is constant 0.
//
// Parameters: CLK_DIV (2..255) clk cycles per sclk half period,
//             NCS_GAP (1..255) clk cycles of ncs high after a frame.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_addr, req_data   register address / write data
//   sclk, copi, ncs      SPI bus
//   busy                 high from acceptance until back in IDLE
//   done                 one-cycle pulse as ncs rises at frame end
//   err                  one-cycle pulse on a rejected request
//   dbg_state            current FSM state
// -----------------------------------------------------------------------------
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NCS_GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done,
  output logic       err,
  output spi_state_t dbg_state
);

  localparam logic [7:0] LP_GAP_LAST = 8'(NCS_GAP - 1);
  localparam logic [4:0] LP_LAST_BIT = 5'(SPI_FRAME_W - 1);
  localparam logic [4:0] LP_NBITS    = 5'(SPI_FRAME_W);

  spi_state_t             r_state;
  spi_state_t             w_next;
  logic [SPI_FRAME_W-1:0] r_shift;
  logic [4:0]             r_bit_cnt;
  logic [7:0]             r_gap_cnt;
  logic                   r_sclk;
  logic                   r_ready;
  logic                   r_done;

  logic w_tick;
  logic w_hs;
  logic w_addr_bad;
  logic w_accept;
  logic w_frame_active;
  logic w_gap_last;
  logic w_state_chg;

  // Handshake: a request transfers on a rising clk edge where req_valid and
  // req_ready are both high; req_addr/req_data are captured on that edge and
  // may change freely afterwards. req_ready is high only in IDLE, and a
  // transfer, once started, completes regardless of req_valid.
  assign w_hs = req_valid & r_ready;

`ifdef SPI_CTRL_ADDR_CHECK_EN
  logic r_err;

  assign w_addr_bad = (req_addr > MAX_VALID_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_hs & w_addr_bad;
    end
  end

  assign err = r_err;
`else
  assign w_addr_bad = 1'b0;
  assign err        = 1'b0;
`endif

  assign w_accept       = w_hs & ~w_addr_bad;
  assign w_frame_active = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                          (r_state == ST_HOLD);
  assign w_gap_last     = (r_gap_cnt == LP_GAP_LAST);
  assign w_state_chg    = (w_next != r_state);

  // The divider restarts on every state change so each frame's timing is
  // identical regardless of history.
  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_frame_active),
    .i_clear (w_state_chg),
    .o_tick  (w_tick)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SETUP;
      ST_SETUP: if (w_tick)   w_next = ST_SHIFT;
      // Leave SHIFT only after the low phase that follows the 16th high phase.
      ST_SHIFT: if (w_tick && !r_sclk && (r_bit_cnt == LP_NBITS)) w_next = ST_HOLD;
      ST_HOLD:  if (w_tick)   w_next = ST_GAP;
      ST_GAP:   if (w_gap_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, sclk phase, gap counter, pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= 5'd0;
      r_gap_cnt <= 8'd0;
      r_sclk    <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      // Registered so req_ready stays low during reset and rises on the
      // first edge afterwards.
      r_ready <= (w_next == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift   <= build_frame(req_addr, req_data);
            r_bit_cnt <= 5'd0;
            r_sclk    <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (w_tick) r_sclk <= 1'b1;
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (r_sclk) begin
              // Falling edge: advance copi, except after the last bit so bit 0
              // stays on the wire through HOLD.
              r_sclk    <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt != LP_LAST_BIT) begin
                r_shift <= {r_shift[SPI_FRAME_W-2:0], 1'b0};
              end
            end else if (r_bit_cnt != LP_NBITS) begin
              r_sclk <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_done    <= 1'b1;
            r_gap_cnt <= 8'd0;
          end
        end
        ST_GAP: begin
          if (w_gap_last) begin
            r_gap_cnt <= 8'd0;
            r_bit_cnt <= 5'd0;
            r_shift   <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: begin
          r_sclk <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign sclk      = r_sclk;
  assign ncs       = ~w_frame_active;
  assign copi      = w_frame_active & r_shift[SPI_FRAME_W-1];
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
// Two controller instances: u_dut0 (CLK_DIV=4, NCS_GAP=4) and u_dut1
// (CLK_DIV=2, NCS_GAP=3). A bus monitor decodes each frame the way the
// peripheral would (sample copi on sclk rise, commit on ncs rise) and checks
// it against the expected queue filled by the driver at each handshake.
// -----------------------------------------------------------------------------
module tb_spi_controller;
  import spi_pkg::*;

  localparam int DIV0 = 4;
  localparam int GAP0 = 4;
  localparam int DIV1 = 2;
  localparam int GAP1 = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n_v;
  logic [1:0] valid_v, ready_v, sclk_v, copi_v, ncs_v, busy_v, done_v, err_v;
  logic [6:0] addr_v [2];
  logic [7:0] data_v [2];
  spi_state_t dbg_v  [2];

  spi_controller #(.CLK_DIV(DIV0), .NCS_GAP(GAP0)) u_dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .req_valid(valid_v[0]), .req_addr(addr_v[0]),
    .req_data(data_v[0]), .req_ready(ready_v[0]), .sclk(sclk_v[0]), .copi(copi_v[0]),
    .ncs(ncs_v[0]), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
    .dbg_state(dbg_v[0])
  );

  spi_controller #(.CLK_DIV(DIV1), .NCS_GAP(GAP1)) u_dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .req_valid(valid_v[1]), .req_addr(addr_v[1]),
    .req_data(data_v[1]), .req_ready(ready_v[1]), .sclk(sclk_v[1]), .copi(copi_v[1]),
    .ncs(ncs_v[1]), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
    .dbg_state(dbg_v[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_frames [2];
  int done_cnt   [2];
  int err_cnt    [2];
  int low_cnt    [2];
  int high_cnt   [2];
  int rises      [2];
  int min_gap    [2];
  bit have_prev  [2];
  bit aborted    [2];
  logic [15:0] shreg [2];
  logic [7:0]  regs  [2][5];
  logic [1:0]  prev_sclk, prev_ncs, prev_copi;
  int copi_viol = 0;
  int rb_viol   = 0;
  int mon_div;
  logic [15:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / peripheral model (samples on the falling clk edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (busy_v[k] && ready_v[k]) rb_viol++;
      if (sclk_v[k] && prev_sclk[k] && (copi_v[k] !== prev_copi[k])) copi_viol++;
      if (done_v[k]) done_cnt[k]++;
      if (err_v[k]) err_cnt[k]++;
      if (!ncs_v[k]) begin
        if (prev_ncs[k]) begin
          if (have_prev[k] && (high_cnt[k] < min_gap[k])) min_gap[k] = high_cnt[k];
          low_cnt[k] = 1;
          rises[k]   = 0;
          shreg[k]   = '0;
        end else begin
          low_cnt[k]++;
        end
        if (sclk_v[k] && !prev_sclk[k]) begin
          rises[k]++;
          shreg[k] = {shreg[k][14:0], copi_v[k]};
        end
      end else begin
        if (!prev_ncs[k]) begin
          if (aborted[k]) begin
            chk("abort_no_done", 32'(done_v[k]), 32'd0);
            aborted[k]   = 1'b0;
            have_prev[k] = 1'b0;
          end else begin
            mon_div = (k == 0) ? DIV0 : DIV1;
            chk("done_with_ncs_rise", 32'(done_v[k]), 32'd1);
            chk("ncs_low_cycles", 32'(low_cnt[k]), 32'(34 * mon_div));
            chk("sclk_rises", 32'(rises[k]), 32'd16);
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
              n_checks++;
              $display("FAIL unexpected_frame: got 0x%0h, expected no frame", shreg[k]);
            end else begin
              if (k == 0) mon_exp = exp_q0.pop_front();
              else        mon_exp = exp_q1.pop_front();
              chk("frame", 32'(shreg[k]), 32'(mon_exp));
            end
            have_prev[k] = 1'b1;
          end
          if (rises[k] == 16 && shreg[k][15] && (shreg[k][14:8] <= 7'd4))
            regs[k][shreg[k][10:8]] = shreg[k][7:0];
          high_cnt[k] = 1;
        end else begin
          high_cnt[k]++;
        end
      end
      prev_sclk[k] = sclk_v[k];
      prev_ncs[k]  = ncs_v[k];
      prev_copi[k] = copi_v[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input int k, input logic [6:0] a, input logic [7:0] d,
                      input logic [15:0] exp_frame, input bit hold);
    int n;
    bit bad;
    n   = 0;
    bad = 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
    bad = (a > 7'd4);
`endif
    @(negedge clk);
    valid_v[k] = 1'b1;
    addr_v[k]  = a;
    data_v[k]  = d;
    while (!ready_v[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[k]) begin
      chk("handshake_timeout", 32'(ready_v[k]), 32'd1);
      valid_v[k] = 1'b0;
    end else begin
      if (!bad) begin
        if (k == 0) exp_q0.push_back(exp_frame);
        else        exp_q1.push_back(exp_frame);
        exp_frames[k]++;
      end
      @(posedge clk);
      #1;
      if (!hold) begin
        valid_v[k] = 1'b0;
        addr_v[k]  = 7'($urandom_range(0, 127));
        data_v[k]  = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_v[k] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy_v[k]) chk("idle_timeout", 32'(busy_v[k]), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int n;
  int exp_err;

  initial begin
    rst_n_v   = 2'b00;
    valid_v   = 2'b00;
    prev_sclk = 2'b00;
    prev_ncs  = 2'b11;
    prev_copi = 2'b00;
    for (int k = 0; k < 2; k++) begin
      addr_v[k]     = 7'd0;
      data_v[k]     = 8'd0;
      exp_frames[k] = 0;
      done_cnt[k]   = 0;
      err_cnt[k]    = 0;
      low_cnt[k]    = 0;
      high_cnt[k]   = 0;
      rises[k]      = 0;
      min_gap[k]    = 1000;
      have_prev[k]  = 1'b0;
      aborted[k]    = 1'b0;
      shreg[k]      = '0;
      for (int r = 0; r < 5; r++) regs[k][r] = 8'h00;
    end

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ncs",   32'(ncs_v[0]),   32'd1);
    chk("rst_sclk",  32'(sclk_v[0]),  32'd0);
    chk("rst_copi",  32'(copi_v[0]),  32'd0);
    chk("rst_busy",  32'(busy_v[0]),  32'd0);
    chk("rst_done",  32'(done_v[0]),  32'd0);
    chk("rst_err",   32'(err_v[0]),   32'd0);
    chk("rst_ready", 32'(ready_v[0]), 32'd0);
    chk("rst_state", 32'(dbg_v[0]),   32'(ST_IDLE));
    @(negedge clk);
    rst_n_v = 2'b11;
    #1;
    chk("ready_low_before_edge", 32'(ready_v[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge0", 32'(ready_v[0]), 32'd1);
    chk("ready_after_first_edge1", 32'(ready_v[1]), 32'd1);

    // Single write: addr 0x04 data 0xA5
    send(0, ADDR_PWM_DUTY, 8'hA5, 16'h84A5, 1'b0);
    chk("busy_after_accept", 32'(busy_v[0]), 32'd1);
    chk("state_after_accept", 32'(dbg_v[0]), 32'(ST_SETUP));
    wait_idle(0);

    // Back-to-back writes into the register map
    send(0, ADDR_PWM_7_0, 8'h3C, 16'h823C, 1'b0);
    send(0, ADDR_OUT_7_0, 8'hFF, 16'h80FF, 1'b0);
    wait_idle(0);
    chk("reg_pwm_7_0", 32'(regs[0][2]), 32'h3C);
    chk("reg_out_7_0", 32'(regs[0][0]), 32'hFF);

    // Reset in the middle of bit 7
    send(0, ADDR_PWM_15_8, 8'h77, 16'h8377, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (rises[0] < 8 && n < 2000);
    if (rises[0] < 8) chk("bit7_timeout", 32'(rises[0]), 32'd8);
    rst_n_v[0] = 1'b0;
    aborted[0] = 1'b1;
    exp_q0.delete();
    exp_frames[0]--;
    #1;
    chk("abort_ncs",   32'(ncs_v[0]),   32'd1);
    chk("abort_sclk",  32'(sclk_v[0]),  32'd0);
    chk("abort_copi",  32'(copi_v[0]),  32'd0);
    chk("abort_busy",  32'(busy_v[0]),  32'd0);
    chk("abort_ready", 32'(ready_v[0]), 32'd0);
    chk("abort_state", 32'(dbg_v[0]),   32'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n_v[0] = 1'b1;
    #1;
    chk("abort_ready_before_edge", 32'(ready_v[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_ready_after_edge", 32'(ready_v[0]), 32'd1);
    chk("abort_reg3_unchanged", 32'(regs[0][3]), 32'h00);
    chk("abort_reg2_unchanged", 32'(regs[0][2]), 32'h3C);

    // Out-of-map address, then a normal write
`ifdef SPI_CTRL_ADDR_CHECK_EN
    send(0, 7'h05, 8'h66, 16'h0000, 1'b0);
    chk("reject_err_pulse", 32'(err_v[0]), 32'd1);
    chk("reject_ncs_high",  32'(ncs_v[0]), 32'd1);
    chk("reject_state",     32'(dbg_v[0]), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    chk("reject_err_one_cycle", 32'(err_v[0]), 32'd0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (!ncs_v[0]) n++;
    end
    chk("reject_no_frame", 32'(n), 32'd0);
    exp_err = 1;
`else
    send(0, 7'h05, 8'h66, 16'h8566, 1'b0);
    exp_err = 0;
`endif
    send(0, ADDR_OUT_15_8, 8'h12, 16'h8112, 1'b0);
    wait_idle(0);
    chk("reg_out_15_8", 32'(regs[0][1]), 32'h12);

    // CLK_DIV=2 instance: request held valid for three writes
    send(1, ADDR_OUT_7_0,  8'h11, 16'h8011, 1'b1);
    send(1, ADDR_PWM_15_8, 8'h22, 16'h8322, 1'b1);
    send(1, ADDR_PWM_DUTY, 8'h33, 16'h8433, 1'b0);
    wait_idle(1);
    chk("dut1_reg0", 32'(regs[1][0]), 32'h11);
    chk("dut1_reg3", 32'(regs[1][3]), 32'h22);
    chk("dut1_reg4", 32'(regs[1][4]), 32'h33);
    chk("dut1_done_count", 32'(done_cnt[1]), 32'd3);

    // Final scoreboard checks
    repeat (4) @(negedge clk);
    chk("dut0_queue_empty", 32'(exp_q0.size()), 32'd0);
    chk("dut1_queue_empty", 32'(exp_q1.size()), 32'd0);
    chk("dut0_done_count", 32'(done_cnt[0]), 32'(exp_frames[0]));
    chk("dut1_frames", 32'(exp_frames[1]), 32'd3);
    chk("dut0_err_count", 32'(err_cnt[0]), 32'(exp_err));
    chk("dut1_err_count", 32'(err_cnt[1]), 32'd0);
    chk("dut0_min_ncs_gap", 32'(min_gap[0]), 32'(GAP0 + 1));
    chk("dut1_min_ncs_gap", 32'(min_gap[1]), 32'(GAP1 + 1));
    chk("copi_stable_while_sclk_high", 32'(copi_viol), 32'd0);
    chk("ready_low_while_busy", 32'(rb_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
